// File: rtl/serdes_pkg.sv
// Shared 8b/10b link constants and receive-aligner state encoding.
// Also used by the encoder and decoder; contains no logic.
package serdes_pkg;
    localparam int WORD_W = 10;

    // K28.5 patterns; bit 9 is the first bit on the wire.
    localparam logic [WORD_W-1:0] K28_5_NEG = 10'b0011111010;
    localparam logic [WORD_W-1:0] K28_5_POS = 10'b1100000101;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } rx_align_state_t;
endpackage

// File: rtl/serdes_comma_detect.sv
// Serial-in shift register with a K28.5 (either disparity) match on its contents.
// match is combinational from sr, one cycle after the last comma bit is sampled; no backpressure.
module serdes_comma_detect
    import serdes_pkg::*;
#(
    parameter logic [WORD_W-1:0] COMMA_NEG = K28_5_NEG,
    parameter logic [WORD_W-1:0] COMMA_POS = K28_5_POS
) (
    input  logic              Clk,
    input  logic              resetN,
    input  logic              Sin,
    output logic [WORD_W-1:0] sr,
    output logic              match
);

    always_ff @(posedge Clk or negedge resetN) begin
        if (!resetN) begin
            sr <= '0;
        end else begin
            sr <= {sr[WORD_W-2:0], Sin};
        end
    end

    assign match = (sr == COMMA_NEG) || (sr == COMMA_POS);

endmodule

// File: rtl/rx_word_align.sv
// Comma-locked 10-bit word aligner; RX_REALIGN_EN enables in-lock boundary correction.
// Word strobe one cycle after a group's last bit; streaming with no backpressure.
module rx_word_align
    import serdes_pkg::*;
#(
    parameter int                LOCK_COMMAS = 4,
    parameter int                MISS_LIMIT  = 3,
    parameter logic [WORD_W-1:0] COMMA_NEG   = K28_5_NEG,
    parameter logic [WORD_W-1:0] COMMA_POS   = K28_5_POS
) (
    input  logic              Clk,
    input  logic              resetN,
    input  logic              Sin,
    output logic [WORD_W-1:0] word,
    output logic              wordValid,
    output logic              isComma,
    output logic              locked,
    output logic              realign
);

    localparam logic [3:0] LOCK_N = LOCK_COMMAS[3:0];
    localparam logic [2:0] MISS_N = MISS_LIMIT[2:0];

    rx_align_state_t   state;
    rx_align_state_t   state_next;
    logic [WORD_W-1:0] sr;
    logic              match;
    logic [3:0]        phase;
    logic [3:0]        comma_cnt;
    logic [2:0]        miss_cnt;
    logic              boundary;
    logic              misaligned;
    logic [3:0]        comma_cnt_inc;
    logic [2:0]        miss_cnt_inc;

    serdes_comma_detect #(
        .COMMA_NEG (COMMA_NEG),
        .COMMA_POS (COMMA_POS)
    ) u_comma_detect (
        .Clk    (Clk),
        .resetN (resetN),
        .Sin    (Sin),
        .sr     (sr),
        .match  (match)
    );

    assign boundary      = (phase == 4'd9);
    // A comma coinciding with the boundary is always treated as aligned.
    assign misaligned    = match && !boundary;
    assign comma_cnt_inc = (comma_cnt == 4'hF) ? comma_cnt : comma_cnt + 4'd1;
    assign miss_cnt_inc  = (miss_cnt == 3'h7) ? miss_cnt : miss_cnt + 3'd1;

    always_ff @(posedge Clk or negedge resetN) begin
        if (!resetN) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HUNT: begin
                if (match) state_next = CONFIRM;
            end
            CONFIRM: begin
                if (boundary) begin
                    if (!match)                       state_next = HUNT;
                    else if (comma_cnt_inc >= LOCK_N) state_next = LOCKED;
                end
            end
            LOCKED: begin
`ifdef RX_REALIGN_EN
                state_next = LOCKED;
`else
                if (misaligned && (miss_cnt_inc >= MISS_N)) state_next = HUNT;
`endif
            end
            default: state_next = HUNT;
        endcase
    end

    always_comb begin
        locked = 1'b0;
        if (state == LOCKED) locked = 1'b1;
    end

    always_ff @(posedge Clk or negedge resetN) begin
        if (!resetN) begin
            phase     <= 4'd0;
            comma_cnt <= 4'd0;
            miss_cnt  <= 3'd0;
            word      <= '0;
            wordValid <= 1'b0;
            isComma   <= 1'b0;
        end else begin
            wordValid <= 1'b0;
            phase     <= boundary ? 4'd0 : phase + 4'd1;
            case (state)
                HUNT: begin
                    if (match) begin
                        phase     <= 4'd0;
                        comma_cnt <= 4'd1;
                    end
                end
                CONFIRM: begin
                    if (boundary) comma_cnt <= match ? comma_cnt_inc : 4'd0;
                end
                LOCKED: begin
                    if (boundary) begin
                        word      <= sr;
                        wordValid <= 1'b1;
                        isComma   <= match;
                        if (match) miss_cnt <= 3'd0;
                    end else if (match) begin
`ifdef RX_REALIGN_EN
                        phase <= 4'd0;
`else
                        miss_cnt <= miss_cnt_inc;
                        if (miss_cnt_inc >= MISS_N) begin
                            miss_cnt  <= 3'd0;
                            comma_cnt <= 4'd0;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RX_REALIGN_EN
    always_ff @(posedge Clk or negedge resetN) begin
        if (!resetN) begin
            realign <= 1'b0;
        end else begin
            realign <= (state == LOCKED) && misaligned;
        end
    end
`else
    assign realign = 1'b0;
`endif

endmodule

// File: tb/tb_rx_word_align.sv
// Directed bench for rx_word_align: reset, acquisition, abort, data path, slip, reset mid-lock.
// Handles both RX_REALIGN_EN builds.
module tb_rx_word_align;
    import serdes_pkg::*;

    localparam logic [9:0] NEG  = 10'b0011111010;
    localparam logic [9:0] POS  = 10'b1100000101;
    localparam logic [9:0] D3C5 = 10'h3C5;
    localparam logic [9:0] D215 = 10'b1010101010;

    logic       Clk = 1'b0;
    logic       resetN;
    logic       Sin;
    logic [9:0] word;
    logic       wordValid;
    logic       isComma;
    logic       locked;
    logic       realign;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int         vld_cnt = 0;
    int         vld_cyc  [0:511];
    logic [9:0] vld_word [0:511];
    logic       vld_isc  [0:511];
    int         rea_cnt       = 0;
    int         rea_cyc       = 0;
    int         lock_rise_cnt = 0;
    int         lock_rise_cyc = -1;
    logic       locked_q      = 1'b0;

    rx_word_align dut (
        .Clk       (Clk),
        .resetN    (resetN),
        .Sin       (Sin),
        .word      (word),
        .wordValid (wordValid),
        .isComma   (isComma),
        .locked    (locked),
        .realign   (realign)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle; cyc names the edge that produced the value.
    always @(negedge Clk) begin
        if (wordValid === 1'b1) begin
            if (vld_cnt < 512) begin
                vld_cyc[vld_cnt]  = cyc;
                vld_word[vld_cnt] = word;
                vld_isc[vld_cnt]  = isComma;
            end
            vld_cnt = vld_cnt + 1;
        end
        if (realign === 1'b1) begin
            rea_cnt = rea_cnt + 1;
            rea_cyc = cyc;
        end
        if (locked === 1'b1 && locked_q !== 1'b1) begin
            lock_rise_cnt = lock_rise_cnt + 1;
            lock_rise_cyc = cyc;
        end
        locked_q = locked;
    end

    task automatic send_bit(input logic b);
        Sin = b;
        @(posedge Clk);
        #1;
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic test_reset();
        int base;
        resetN = 1'b0;
        for (int i = 0; i < 12; i++) send_bit(i[0]);
        n_vec++;
        if (word !== 10'd0) begin
            n_err++; $display("FAIL reset_word: got %h want 000", word);
        end
        n_vec++;
        if ({wordValid, isComma, locked, realign} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: got %b want 0000", {wordValid, isComma, locked, realign});
        end
        n_vec++;
        if (dut.state !== HUNT) begin
            n_err++; $display("FAIL reset_state: got %0d want %0d", dut.state, HUNT);
        end
        resetN = 1'b1;
        base = vld_cnt;
        send_word(D3C5);
        send_word(D3C5);
        n_vec++;
        if ((vld_cnt - base) != 0 || locked !== 1'b0) begin
            n_err++; $display("FAIL reset_no_vld: strobes %0d locked %b want 0 0", vld_cnt - base, locked);
        end
    endtask

    task automatic test_acquisition();
        int base, t1;
        base = vld_cnt;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_word(NEG); t1 = cyc;
        send_word(POS); send_word(NEG); send_word(POS);
        n_vec++;
        if (locked !== 1'b0) begin
            n_err++; $display("FAIL acq_early: locked %b want 0", locked);
        end
        send_word(D3C5); send_word(D3C5);
        n_vec++;
        if (lock_rise_cyc != t1 + 31 || locked !== 1'b1) begin
            n_err++; $display("FAIL acq_lock_time: rose at %0d locked %b want %0d 1", lock_rise_cyc, locked, t1 + 31);
        end
        n_vec++;
        if ((vld_cnt - base) != 1 || vld_cyc[base] != t1 + 41) begin
            n_err++; $display("FAIL acq_first_vld: count %0d at %0d want 1 at %0d", vld_cnt - base, vld_cyc[base], t1 + 41);
        end
        n_vec++;
        if (vld_word[base] !== D3C5 || vld_isc[base] !== 1'b0) begin
            n_err++; $display("FAIL acq_first_word: got %h/%b want 3c5/0", vld_word[base], vld_isc[base]);
        end
    endtask

    task automatic test_data_path();
        int base;
        logic [9:0] exp_w [0:4];
        logic       exp_c [0:4];
        exp_w = '{D3C5, D3C5, NEG, D3C5, POS};
        exp_c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        base = vld_cnt;
        send_word(D3C5); send_word(NEG); send_word(D3C5); send_word(POS); send_word(D3C5);
        n_vec++;
        if ((vld_cnt - base) != 5) begin
            n_err++; $display("FAIL data_count: got %0d want 5", vld_cnt - base);
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (vld_word[base+i] !== exp_w[i] || vld_isc[base+i] !== exp_c[i]) begin
                n_err++; $display("FAIL data_word%0d: got %h/%b want %h/%b", i, vld_word[base+i], vld_isc[base+i], exp_w[i], exp_c[i]);
            end
            n_vec++;
            if (vld_cyc[base+i] - vld_cyc[base+i-1] != 10) begin
                n_err++; $display("FAIL data_gap%0d: got %0d want 10", i, vld_cyc[base+i] - vld_cyc[base+i-1]);
            end
        end
        n_vec++;
        if (locked !== 1'b1) begin
            n_err++; $display("FAIL data_locked: got %b want 1", locked);
        end
    endtask

    task automatic test_abort();
        int base_rise, t1;
        resetN = 1'b0;
        send_bit(1'b0); send_bit(1'b0);
        resetN = 1'b1;
        base_rise = lock_rise_cnt;
        send_word(NEG); send_word(POS); send_word(D215);
        send_word(NEG); t1 = cyc;
        send_word(POS); send_word(NEG);
        n_vec++;
        if (locked !== 1'b0) begin
            n_err++; $display("FAIL abort_no_lock: locked %b want 0", locked);
        end
        send_word(POS); send_word(D3C5);
        n_vec++;
        if ((lock_rise_cnt - base_rise) != 1 || lock_rise_cyc != t1 + 31) begin
            n_err++; $display("FAIL abort_relock: rises %0d at %0d want 1 at %0d", lock_rise_cnt - base_rise, lock_rise_cyc, t1 + 31);
        end
    endtask

    task automatic test_slip();
        int base_v, base_r, base_rise, t1, k;
        base_v    = vld_cnt;
        base_r    = rea_cnt;
        base_rise = lock_rise_cnt;
        send_word(D3C5);
        send_bit(1'b0);
`ifdef RX_REALIGN_EN
        send_word(NEG); t1 = cyc;
        send_word(D3C5); send_word(D3C5);
        n_vec++;
        if ((rea_cnt - base_r) != 1 || rea_cyc != t1 + 1) begin
            n_err++; $display("FAIL slip_realign: pulses %0d at %0d want 1 at %0d", rea_cnt - base_r, rea_cyc, t1 + 1);
        end
        n_vec++;
        if (locked !== 1'b1 || lock_rise_cnt != base_rise) begin
            n_err++; $display("FAIL slip_held: locked %b rises %0d want 1 0", locked, lock_rise_cnt - base_rise);
        end
        k = -1;
        for (int i = vld_cnt - 1; i >= base_v; i--) if (vld_cyc[i] > rea_cyc) k = i;
        n_vec++;
        if (k <= base_v || vld_cyc[k] != rea_cyc + 10 || vld_cyc[k-1] >= rea_cyc) begin
            n_err++; $display("FAIL slip_next_vld: index %0d at %0d want at %0d", k, (k >= 0) ? vld_cyc[k] : -1, rea_cyc + 10);
        end else begin
            n_vec++;
            if (vld_word[k] !== D3C5 || vld_isc[k] !== 1'b0) begin
                n_err++; $display("FAIL slip_next_word: got %h/%b want 3c5/0", vld_word[k], vld_isc[k]);
            end
        end
`else
        send_word(NEG); send_word(POS);
        n_vec++;
        if (locked !== 1'b1) begin
            n_err++; $display("FAIL slip_two_held: locked %b want 1", locked);
        end
        send_word(NEG);
        send_word(POS); t1 = cyc;
        n_vec++;
        if (locked !== 1'b0) begin
            n_err++; $display("FAIL slip_drop: locked %b want 0", locked);
        end
        send_word(NEG); send_word(POS); send_word(NEG); send_word(D3C5);
        n_vec++;
        if ((lock_rise_cnt - base_rise) != 1 || lock_rise_cyc != t1 + 31 || locked !== 1'b1) begin
            n_err++; $display("FAIL slip_relock: rises %0d at %0d locked %b want 1 at %0d 1", lock_rise_cnt - base_rise, lock_rise_cyc, locked, t1 + 31);
        end
        n_vec++;
        if (rea_cnt != base_r) begin
            n_err++; $display("FAIL slip_realign_tied: pulses %0d want 0", rea_cnt - base_r);
        end
`endif
    endtask

    task automatic test_reset_mid_lock();
        int base_v, base_rise, t1;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        n_vec++;
        if (locked !== 1'b1) begin
            n_err++; $display("FAIL midrst_pre: locked %b want 1", locked);
        end
        #2;
        resetN = 1'b0;
        #1;
        n_vec++;
        if ({locked, wordValid, isComma, realign} !== 4'b0000 || word !== 10'd0) begin
            n_err++; $display("FAIL midrst_async: flags %b word %h want 0000 000", {locked, wordValid, isComma, realign}, word);
        end
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        resetN = 1'b1;
        base_v    = vld_cnt;
        base_rise = lock_rise_cnt;
        send_word(NEG); t1 = cyc;
        send_word(POS); send_word(NEG); send_word(POS);
        send_word(D3C5); send_word(D3C5);
        n_vec++;
        if ((lock_rise_cnt - base_rise) != 1 || lock_rise_cyc != t1 + 31) begin
            n_err++; $display("FAIL midrst_relock: rises %0d at %0d want 1 at %0d", lock_rise_cnt - base_rise, lock_rise_cyc, t1 + 31);
        end
        n_vec++;
        if ((vld_cnt - base_v) != 1 || vld_cyc[base_v] != t1 + 41 || vld_word[base_v] !== D3C5) begin
            n_err++; $display("FAIL midrst_first_vld: count %0d at %0d word %h want 1 at %0d 3c5", vld_cnt - base_v, vld_cyc[base_v], vld_word[base_v], t1 + 41);
        end
    endtask

    initial begin
        resetN = 1'b0;
        Sin    = 1'b0;
        test_reset();
        test_acquisition();
        test_data_path();
        test_abort();
        test_slip();
        test_reset_mid_lock();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_word_align.md
# rx_word_align

Receive-side word aligner for the 8b/10b serial link. Consumes the single-bit serial stream produced by the transmitter (sampled on the shared Clk), hunts for the K28.5 comma, locks 10-bit word boundaries, and presents aligned 10-bit code groups with a valid strobe to the downstream 8b/10b decoder. Owns link-lock status for the receiver.

## Interface
- LOCK_COMMAS, 4: consecutive boundary-aligned commas required to declare lock (range 2–15).
- MISS_LIMIT, 3: consecutive misaligned commas tolerated in LOCKED before falling back to HUNT (range 1–7).
- COMMA_NEG, 10'b0011111010: K28.5 RD− pattern, bit 9 = first bit on the wire.
- COMMA_POS, 10'b1100000101: K28.5 RD+ pattern.
- Clk  input  1  link bit clock; all state updates on posedge.
- resetN  input  1  reset, asynchronous, active-low.
- Sin  input  1  serial data, one bit per Clk, MSB-first per code group.
- word  output  10  aligned code group, bit 9 = first received bit.
- wordValid  output  1  one-cycle strobe, word valid.
- isComma  output  1  qualifies wordValid: word equals COMMA_NEG or COMMA_POS.
- locked  output  1  high in LOCKED state.
- realign  output  1  one-cycle pulse on in-lock boundary correction (RX_REALIGN_EN only; constant 0 otherwise).

## Operation
- Shift register sr[9:0]: every Clk, sr <= {sr[8:0], Sin}. Comma match = combinational compare of sr against COMMA_NEG/COMMA_POS.
- Phase counter 0..9, wraps 9→0; boundary = phase==9.
- States (encoding in package): HUNT, CONFIRM, LOCKED.
- HUNT: match in any cycle → phase<=0, commaCnt<=1, go CONFIRM. No wordValid.
- CONFIRM: at each boundary: match → commaCnt+1; commaCnt reaching LOCK_COMMAS → LOCKED. Non-comma at boundary → HUNT, commaCnt<=0. No wordValid. Off-boundary matches ignored.
- LOCKED: at each boundary: word<=sr, wordValid<=1, isComma<=match. Aligned comma clears missCnt. Non-comma data accepted unconditionally (decoder flags code errors).
- Misaligned comma in LOCKED (match with phase!=9): handling per Configuration.
- Leaving LOCKED: locked drops same edge as state change; no further wordValid.
- commaCnt 4 bits, missCnt 3 bits, saturating; never wrap.

## Timing
- Reset values: sr=0, phase=0, state=HUNT, commaCnt=0, missCnt=0, word=0, wordValid=0, isComma=0, locked=0, realign=0. Reset mid-operation returns all to these values immediately (async); acquisition restarts from HUNT after release.
- Latency: last bit of a code group sampled at edge t → word/wordValid/isComma updated at edge t+1.
- In LOCKED, wordValid strobes exactly every 10 cycles; never two within 10 cycles except across a realign.
- Minimum lock time: first comma + (LOCK_COMMAS−1)×10 cycles; locked rises on the edge following the LOCK_COMMAS-th comma's boundary.
- Comma match and boundary in same cycle: treated as aligned comma (never as misaligned).

## Configuration
- RX_REALIGN_EN defined: misaligned comma in LOCKED → phase<=0, realign pulses 1 cycle, state stays LOCKED, locked stays 1; the partial word at the old boundary is not emitted; next wordValid 10 cycles later carries the word after the comma.
- RX_REALIGN_EN undefined: misaligned comma → missCnt+1, phase unchanged; missCnt reaching MISS_LIMIT → HUNT, locked<=0. realign tied 0.

## Structure
- Shared package serdes_pkg: K28_5_NEG/K28_5_POS constants (also consumed by encoder/decoder), rx_align_state_t enum {HUNT, CONFIRM, LOCKED}, word width constant 10.
- One sub-module: serdes_comma_detect (sr register + dual-pattern compare, outputs sr and match); shared with future bit-error monitor.

## Test plan
- Reset: resetN low with Sin toggling → all outputs 0, state HUNT; release → no wordValid until lock.
- Acquisition: 4 back-to-back RD−/RD+ K28.5 at arbitrary start offset 3 → locked rises 31 cycles after first comma's last bit; first wordValid follows on next boundary.
- Abort: comma, comma, then D21.5 (1010101010) at boundary → returns HUNT, locked stays 0; 4 fresh commas then lock.
- Data path: locked, stream 0x3C5 code groups then comma → wordValid every 10 cycles, word=0x3C5 with isComma=0, comma word with isComma=1.
- Slip: locked, insert one extra bit before a comma → macro off: 3 slipped commas drop locked, relock after 4 aligned; macro on: realign pulse, locked held, next wordValid 10 cycles after comma.
- Reset mid-lock: assert resetN low while LOCKED mid-word → locked/wordValid 0 immediately; relock normally after release.
